// File: rtl/adder_chunk_sequencer_pkg.sv
// Shared types and sizing helpers for the chunked wide-add sequencer.
package adder_chunk_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefChunkW = 26;

  function automatic int unsigned total_w(input int unsigned chunk_w,
                                          input int unsigned num_chunks);
    return chunk_w * num_chunks;
  endfunction

endpackage

// File: rtl/adder_chunk_sequencer_if.sv
// Request/result handshake bundle between a requester and the chunk sequencer.
interface adder_chunk_sequencer_if
  import adder_chunk_sequencer_pkg::*;
#(
  parameter int unsigned CHUNK_W    = DefChunkW,
  parameter int unsigned NUM_CHUNKS = 4
) ();

  localparam int unsigned TOTAL_W = total_w(CHUNK_W, NUM_CHUNKS);

  logic               in_valid;
  logic               in_ready;
  logic [TOTAL_W-1:0] in_a;
  logic [TOTAL_W-1:0] in_b;
  logic               in_cin;
  logic               out_valid;
  logic               out_ready;
  logic [TOTAL_W-1:0] out_sum;
  logic               out_cout;
  logic               busy;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );

endinterface

// File: rtl/adder.sv
// Combinational Kogge-Stone prefix adder; carry-in is folded in as bit -1 of the prefix tree.
module adder #(
  parameter int unsigned CHUNK_W = 26
) (
  input  logic [CHUNK_W-1:0] a_i,
  input  logic [CHUNK_W-1:0] b_i,
  input  logic               cin_i,
  output logic [CHUNK_W-1:0] sum_o,
  output logic               cout_o
);

  localparam int unsigned Levels = $clog2(CHUNK_W + 1);

  logic [CHUNK_W:0] gen, prop, gen_nx, prop_nx;

  // After the last level gen[i] is the group generate over extended bits [0..i],
  // i.e. the carry into operand bit i (gen[CHUNK_W] is the carry out).
  always_comb begin
    gen     = {a_i & b_i, cin_i};
    prop    = {a_i ^ b_i, 1'b0};
    gen_nx  = '0;
    prop_nx = '0;
    for (int lvl = 0; lvl < int'(Levels); lvl++) begin
      gen_nx  = gen;
      prop_nx = prop;
      for (int i = (1 << lvl); i <= int'(CHUNK_W); i++) begin
        gen_nx[i]  = gen[i] | (prop[i] & gen[i - (1 << lvl)]);
        prop_nx[i] = prop[i] & prop[i - (1 << lvl)];
      end
      gen  = gen_nx;
      prop = prop_nx;
    end
  end

  assign sum_o  = a_i ^ b_i ^ gen[CHUNK_W-1:0];
  assign cout_o = gen[CHUNK_W];

endmodule

// File: rtl/adder_chunk_sequencer.sv
// Drives an external CHUNK_W-bit adder one slice per cycle, LSB first, chaining the carry,
// and assembles the NUM_CHUNKS-slice result behind a valid/ready handshake.
module adder_chunk_sequencer
  import adder_chunk_sequencer_pkg::*;
#(
  parameter int unsigned CHUNK_W    = DefChunkW,
  parameter int unsigned NUM_CHUNKS = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  adder_chunk_sequencer_if.slave        bus,
  output logic [CHUNK_W-1:0]            add_a,
  output logic [CHUNK_W-1:0]            add_b,
  output logic                          add_cin,
  input  logic [CHUNK_W-1:0]            add_sum,
  input  logic                          add_cout
);

  localparam int unsigned IdxW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_CHUNKS - 1);

  typedef logic [NUM_CHUNKS-1:0][CHUNK_W-1:0] chunks_t;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;
  chunks_t         a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            out_cout_q, out_cout_d;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    out_cout_d  = out_cout_q;
    add_a       = '0;
    add_b       = '0;
    add_cin     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        // Explicit slice mux keeps idx width independent of NUM_CHUNKS being a power of two.
        for (int k = 0; k < int'(NUM_CHUNKS); k++) begin
          if (idx_q == IdxW'(k)) begin
            add_a    = a_q[k];
            add_b    = b_q[k];
            sum_d[k] = add_sum;
          end
        end
        add_cin = carry_q;
        carry_d = add_cout;
        if (idx_q == LastIdx) begin
          out_cout_d  = add_cout;
          out_valid_d = 1'b1;
          idx_d       = '0;
          state_d     = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      out_cout_q <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      out_cout_q <= out_cout_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = out_cout_q;

endmodule

// File: tb/tb_adder_chunk_sequencer.sv
// Directed and randomized checks of the chunk sequencer with the prefix adder attached.
module tb_adder_chunk_sequencer;
  import adder_chunk_sequencer_pkg::*;

  localparam int unsigned CW = DefChunkW;
  localparam int unsigned NC = 4;
  localparam int unsigned TW = CW * NC;
  localparam int          MaxWait = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_chunk_sequencer_if #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) bus4 ();
  adder_chunk_sequencer_if #(.CHUNK_W(CW), .NUM_CHUNKS(1))  bus1 ();

  logic [CW-1:0] a4_a, a4_b, a4_sum, a1_a, a1_b, a1_sum;
  logic          a4_cin, a4_cout, a1_cin, a1_cout;

  adder_chunk_sequencer #(.CHUNK_W(CW), .NUM_CHUNKS(NC)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .add_a(a4_a), .add_b(a4_b), .add_cin(a4_cin), .add_sum(a4_sum), .add_cout(a4_cout)
  );
  adder #(.CHUNK_W(CW)) u_add4 (
    .a_i(a4_a), .b_i(a4_b), .cin_i(a4_cin), .sum_o(a4_sum), .cout_o(a4_cout)
  );

  adder_chunk_sequencer #(.CHUNK_W(CW), .NUM_CHUNKS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .add_a(a1_a), .add_b(a1_b), .add_cin(a1_cin), .add_sum(a1_sum), .add_cout(a1_cout)
  );
  adder #(.CHUNK_W(CW)) u_add1 (
    .a_i(a1_a), .b_i(a1_b), .cin_i(a1_cin), .sum_o(a1_sum), .cout_o(a1_cout)
  );

  int checks = 0;
  int errors = 0;
  logic mon_en = 1'b0;
  int acc_cnt = 0;
  int res_cnt = 0;

  always @(posedge clk) begin
    if (mon_en && rst_n) begin
      if (bus4.in_valid && bus4.in_ready) acc_cnt <= acc_cnt + 1;
      if (bus4.out_valid && bus4.out_ready) res_cnt <= res_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for in_ready, issues one request, returns the result and accept-to-valid latency.
  task automatic run_op4(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic cin,
                         output logic [TW-1:0] sum, output logic cout, output int lat);
    int w = 0;
    while (!bus4.in_ready && w < MaxWait) begin
      @(posedge clk); #1; w++;
    end
    chk("in_ready_wait", 128'(w < MaxWait), 128'(1));
    bus4.in_a = a; bus4.in_b = b; bus4.in_cin = cin; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0;
    lat = 0;
    while (!bus4.out_valid && lat < MaxWait) begin
      @(posedge clk); #1; lat++;
    end
    sum  = bus4.out_sum;
    cout = bus4.out_cout;
  endtask

  task automatic handshake4();
    bus4.out_ready = 1'b1;
    @(posedge clk); #1;
    bus4.out_ready = 1'b0;
  endtask

  typedef struct {
    string         name;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          cin;
    logic [TW-1:0] sum;
    logic          cout;
  } vec_t;

  vec_t vecs[9];

  initial begin
    logic [TW-1:0] ones, s, ra, rb;
    logic [127:0]  t;
    logic          c, rc, stall_bad;
    logic [TW:0]   exp105;
    int            lat, w, n_stall;

    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_cin = 1'b0;
    bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_cin = 1'b0;
    bus1.out_ready = 1'b0;

    ones = {TW{1'b1}};
    vecs[0] = '{"all1_plus_cin",  ones, '0, 1'b1, '0, 1'b1};
    vecs[1] = '{"slice0_carry",   (TW'(1) << 26) - TW'(1), TW'(1), 1'b0, TW'(1) << 26, 1'b0};
    vecs[2] = '{"small",          TW'(5), TW'(7), 1'b1, TW'(13), 1'b0};
    vecs[3] = '{"top_carry",      TW'(1) << 103, TW'(1) << 103, 1'b0, '0, 1'b1};
    vecs[4] = '{"ripple3",        (TW'(1) << 78) - TW'(1), '0, 1'b1, TW'(1) << 78, 1'b0};
    vecs[5] = '{"zero",           '0, '0, 1'b0, '0, 1'b0};
    vecs[6] = '{"alternating",    {52{2'b10}}, {52{2'b01}}, 1'b0, ones, 1'b0};
    vecs[7] = '{"max_max_cin",    ones, ones, 1'b1, ones, 1'b1};
    vecs[8] = '{"b_ones_cin",     '0, ones, 1'b1, '0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  128'(bus4.in_ready), 128'(1));
    chk("rst_busy",      128'(bus4.busy), 128'(0));
    chk("rst_out_valid", 128'(bus4.out_valid), 128'(0));
    chk("rst_out_sum",   128'(bus4.out_sum), 128'(0));
    chk("rst_out_cout",  128'(bus4.out_cout), 128'(0));
    chk("rst_add_a",     128'(a4_a), 128'(0));
    chk("rst_add_cin",   128'(a4_cin), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed table
    for (int i = 0; i < 9; i++) begin
      run_op4(vecs[i].a, vecs[i].b, vecs[i].cin, s, c, lat);
      chk({vecs[i].name, "_sum"},  128'(s), 128'(vecs[i].sum));
      chk({vecs[i].name, "_cout"}, 128'(c), 128'(vecs[i].cout));
      chk({vecs[i].name, "_lat"},  128'(lat), 128'(4));
      handshake4();
      chk({vecs[i].name, "_valid_drop"}, 128'(bus4.out_valid), 128'(0));
      chk({vecs[i].name, "_ready_back"}, 128'(bus4.in_ready), 128'(1));
    end

    // Output held under backpressure; requests ignored while busy
    run_op4(TW'(123456789), TW'(987654321), 1'b1, s, c, lat);
    chk("hold_first_sum", 128'(s), 128'(1111111111));
    for (int k = 0; k < 10; k++) begin
      bus4.in_valid = ~bus4.in_valid;
      bus4.in_a = TW'($urandom);
      @(posedge clk); #1;
      chk($sformatf("hold_sum_%0d", k),   128'(bus4.out_sum), 128'(1111111111));
      chk($sformatf("hold_cout_%0d", k),  128'(bus4.out_cout), 128'(0));
      chk($sformatf("hold_valid_%0d", k), 128'(bus4.out_valid), 128'(1));
      chk($sformatf("hold_ready_%0d", k), 128'(bus4.in_ready), 128'(0));
    end
    bus4.in_valid = 1'b0;
    bus4.in_a = '0;
    handshake4();
    chk("hold_release_valid", 128'(bus4.out_valid), 128'(0));
    chk("hold_release_ready", 128'(bus4.in_ready), 128'(1));
    chk("hold_sum_retained",  128'(bus4.out_sum), 128'(1111111111));

    // Reset mid-RUN discards the operation
    bus4.in_a = ones; bus4.in_b = '0; bus4.in_cin = 1'b1; bus4.in_valid = 1'b1;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_out_valid", 128'(bus4.out_valid), 128'(0));
    chk("midrst_in_ready",  128'(bus4.in_ready), 128'(1));
    chk("midrst_busy",      128'(bus4.busy), 128'(0));
    w = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus4.out_valid) w++;
    end
    chk("midrst_no_result", 128'(w), 128'(0));
    run_op4(TW'(5), TW'(7), 1'b1, s, c, lat);
    chk("midrst_after_sum", 128'(s), 128'(13));
    chk("midrst_after_lat", 128'(lat), 128'(4));
    handshake4();

    // Randomized operands with stalls
    mon_en = 1'b1;
    stall_bad = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      t  = {$urandom, $urandom, $urandom, $urandom};
      ra = t[TW-1:0];
      t  = {$urandom, $urandom, $urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? ~ra : t[TW-1:0];
      rc = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      run_op4(ra, rb, rc, s, c, lat);
      n_stall = $urandom_range(0, 3);
      for (int k = 0; k < n_stall; k++) begin
        bus4.in_valid = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        if (!bus4.out_valid || bus4.out_sum !== s || bus4.out_cout !== c) stall_bad = 1'b1;
      end
      bus4.in_valid = 1'b0;
      exp105 = {1'b0, ra} + {1'b0, rb} + (TW + 1)'(rc);
      chk($sformatf("rand_%0d", n), 128'({c, s}), 128'(exp105));
      handshake4();
    end
    mon_en = 1'b0;
    chk("rand_stall_hold",  128'(stall_bad), 128'(0));
    chk("rand_acc_vs_res",  128'(acc_cnt), 128'(res_cnt));
    chk("rand_accept_cnt",  128'(acc_cnt), 128'(2000));

    // Single-slice configuration
    w = 0;
    while (!bus1.in_ready && w < MaxWait) begin
      @(posedge clk); #1; w++;
    end
    bus1.in_a = (CW'(1) << 25) | ((CW'(1) << 25) - CW'(1));
    bus1.in_b = CW'(1);
    bus1.in_cin = 1'b0;
    bus1.in_valid = 1'b1;
    @(posedge clk); #1;
    bus1.in_valid = 1'b0;
    lat = 0;
    while (!bus1.out_valid && lat < MaxWait) begin
      @(posedge clk); #1; lat++;
    end
    chk("nc1_lat",  128'(lat), 128'(1));
    chk("nc1_sum",  128'(bus1.out_sum), 128'(0));
    chk("nc1_cout", 128'(bus1.out_cout), 128'(1));
    bus1.out_ready = 1'b1;
    @(posedge clk); #1;
    bus1.out_ready = 1'b0;
    chk("nc1_valid_drop", 128'(bus1.out_valid), 128'(0));
    chk("nc1_ready_back", 128'(bus1.in_ready), 128'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
